// File: rtl/encode_pkg.sv
// Shared definitions for the RC4 encode FSM: state encoding, default
// message length, printable-character bounds and the plaintext check.
package encode_pkg;

   localparam int MSG_LEN_DEFAULT = 32;

   localparam logic [7:0] ASCII_SPACE  = 8'h20;
   localparam logic [7:0] ASCII_LOW_A  = 8'h61;
   localparam logic [7:0] ASCII_LOW_Z  = 8'h7A;

   typedef enum logic [3:0] {
      IDLE,
      RD_I,
      LAT_I,
      RD_J,
      LAT_J,
      WR_I,
      WR_J,
      RD_F,
      WR_C,
      DONE
   } state_t;

   // Plaintext is limited to space and lower-case letters.
   function automatic logic char_valid(input logic [7:0] ch);
      return (ch == ASCII_SPACE) || ((ch >= ASCII_LOW_A) && (ch <= ASCII_LOW_Z));
   endfunction

endpackage

// File: rtl/encode_fsm_if.sv
// Memory-side bus of the encode FSM: S-box RAM, plaintext ROM and
// ciphertext RAM. The FSM is the master; the memories are the slave.
interface encode_fsm_if;

   logic [7:0] s_addr;
   logic [7:0] s_rdata;
   logic [7:0] s_wdata;
   logic       s_we;
   logic [4:0] plain_addr;
   logic [7:0] plain_rdata;
   logic [4:0] cipher_addr;
   logic [7:0] cipher_wdata;
   logic       cipher_we;

   modport master (
      output s_addr, s_wdata, s_we,
      output plain_addr,
      output cipher_addr, cipher_wdata, cipher_we,
      input  s_rdata, plain_rdata
   );

   modport slave (
      input  s_addr, s_wdata, s_we,
      input  plain_addr,
      input  cipher_addr, cipher_wdata, cipher_we,
      output s_rdata, plain_rdata
   );

endinterface

// File: rtl/encode_fsm.sv
// RC4 PRGA encoder. Walks MSG_LEN plaintext bytes, eight cycles per byte,
// swapping S[i]/S[j] in an external synchronous RAM and writing
// keystream XOR plaintext into the ciphertext RAM.
module encode_fsm
   import encode_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   encode_fsm_if.master bus,
   output logic         done,
   output logic         bad_plain
);

   state_t     state_reg, state_next;
   logic [7:0] i_reg, i_next;
   logic [7:0] j_reg, j_next;
   logic [4:0] k_reg, k_next;
   logic [7:0] si_reg, si_next;
   logic [7:0] sj_reg, sj_next;
   logic       bad_reg, bad_next;

   localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

   // State and datapath registers; active-low reset returns everything to IDLE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg <= IDLE;
         i_reg     <= 8'd0;
         j_reg     <= 8'd0;
         k_reg     <= 5'd0;
         si_reg    <= 8'd0;
         sj_reg    <= 8'd0;
         bad_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         k_reg     <= k_next;
         si_reg    <= si_next;
         sj_reg    <= sj_next;
         bad_reg   <= bad_next;
      end
   end

   // Next-state and output decode; memory reads return data one cycle after
   // the address, hence the separate RD_*/LAT_* states.
   always_comb begin
      state_next       = state_reg;
      i_next           = i_reg;
      j_next           = j_reg;
      k_next           = k_reg;
      si_next          = si_reg;
      sj_next          = sj_reg;
      bad_next         = bad_reg;
      done             = 1'b0;
      bus.s_addr       = 8'd0;
      bus.s_wdata      = 8'd0;
      bus.s_we         = 1'b0;
      bus.cipher_wdata = 8'd0;
      bus.cipher_we    = 1'b0;
      bus.plain_addr   = k_reg;
      bus.cipher_addr  = k_reg;

      case (state_reg)
         IDLE: begin
            i_next = 8'd0;
            j_next = 8'd0;
            k_next = 5'd0;
            if (start) begin
               state_next = RD_I;
               i_next     = 8'd1;
               bad_next   = 1'b0;
            end
         end
         RD_I: begin
            bus.s_addr = i_reg;
            state_next = LAT_I;
         end
         LAT_I: begin
            si_next    = bus.s_rdata;
            j_next     = j_reg + bus.s_rdata;
            state_next = RD_J;
         end
         RD_J: begin
            bus.s_addr = j_reg;
            state_next = LAT_J;
         end
         LAT_J: begin
            sj_next    = bus.s_rdata;
            state_next = WR_I;
         end
         WR_I: begin
            bus.s_addr  = i_reg;
            bus.s_wdata = sj_reg;
            bus.s_we    = 1'b1;
            state_next  = WR_J;
         end
         // When i==j this second write lands on the same cell and leaves si there.
         WR_J: begin
            bus.s_addr  = j_reg;
            bus.s_wdata = si_reg;
            bus.s_we    = 1'b1;
            state_next  = RD_F;
         end
         RD_F: begin
            bus.s_addr = si_reg + sj_reg;
            state_next = WR_C;
         end
         WR_C: begin
            bus.cipher_wdata = bus.s_rdata ^ bus.plain_rdata;
            bus.cipher_we    = 1'b1;
            if (!char_valid(bus.plain_rdata)) begin
               bad_next = 1'b1;
            end
            if (k_reg < LAST_K) begin
               k_next     = k_reg + 5'd1;
               i_next     = i_reg + 8'd1;
               state_next = RD_I;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (!start) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bad_plain = bad_reg;

endmodule
